clause_scanner: RTL and testbench

//  Downstream consumer of clause_memory. On start, walks clause addresses 0..num_clauses-1 at one clause/cycle.

---
 rtl/sat_pkg.sv | 57 +++++
 rtl/clause_eval.sv | 94 +++++++++
 rtl/clause_scanner.sv | 212 +++++++++++++++++++++
 tb/tb_clause_scanner.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sat_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sat_pkg
// Description : Shared types for the SAT clause scanning datapath: literal and
//               clause layouts, scan result codes, literal/clause classes and
//               a helper that resolves a literal against one variable's
//               assigned/value bits.
// Revision    : 1.0 - initial release
// ============================================================================
package sat_pkg;

    localparam int VAR_W    = 10;
    localparam int LIT_W    = 11;
    localparam int CLAUSE_W = 33;

    // Literal = {neg, var}; var 0 marks an empty slot.
    typedef struct packed {
        logic             neg;
        logic [VAR_W-1:0] var_id;
    } lit_t;

    // Clause = {lit2, lit1, lit0}, lit0 in the LSBs.
    typedef struct packed {
        lit_t lit2;
        lit_t lit1;
        lit_t lit0;
    } clause_t;

    typedef enum logic [1:0] {
        ST_UNDECIDED = 2'd0,
        ST_ALL_SAT   = 2'd1,
        ST_CONFLICT  = 2'd2,
        ST_UNIT      = 2'd3
    } scan_status_e;

    typedef enum logic [1:0] {
        LIT_UNASSIGNED = 2'd0,
        LIT_TRUE       = 2'd1,
        LIT_FALSE      = 2'd2
    } lit_state_e;

    typedef enum logic [1:0] {
        CLS_SAT      = 2'd0,
        CLS_CONFLICT = 2'd1,
        CLS_UNIT     = 2'd2,
        CLS_OPEN     = 2'd3
    } clause_class_e;

    function automatic lit_state_e lit_state(input logic asg, input logic val, input lit_t lit);
        if (!asg) begin
            return LIT_UNASSIGNED;
        end
        return (val ^ lit.neg) ? LIT_TRUE : LIT_FALSE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clause_eval.sv
`default_nettype none
// ============================================================================
// Module      : clause_eval
// Description : Combinational classifier for one 3-literal clause against the
//               current partial assignment.
//   clause   in  CLAUSE_W  {lit2, lit1, lit0}
//   assigned in  NUM_VARS  1 = variable has a value
//   value    in  NUM_VARS  variable value
//   cls      out 2         clause_class_e: SAT / CONFLICT / UNIT / OPEN
//   unit_lit out LIT_W     the unassigned literal (meaningful for UNIT only)
// Config      : CLAUSE_SCANNER_UNIT_EN defined enables the UNIT class; when
//               undefined a single-unassigned clause is reported as OPEN.
// Revision    : 1.0 - initial release
// ============================================================================
module clause_eval
    import sat_pkg::*;
#(
    parameter int NUM_VARS = 64
) (
    input  logic [CLAUSE_W-1:0] clause,
    input  logic [NUM_VARS-1:0] assigned,
    input  logic [NUM_VARS-1:0] value,
    output logic [1:0]          cls,
    output logic [LIT_W-1:0]    unit_lit
);

    localparam int c_var_space = 2 ** VAR_W;

    clause_t                w_clause;
    lit_t                   w_lits [3];
    lit_state_e             w_state [3];
    logic [c_var_space-1:0] w_asg_ext;
    logic [c_var_space-1:0] w_val_ext;
    logic                   w_any_true;
    logic [1:0]             w_n_unasg;
    lit_t                   w_free_lit;

    assign w_clause = clause;
    assign w_lits[0] = w_clause.lit0;
    assign w_lits[1] = w_clause.lit1;
    assign w_lits[2] = w_clause.lit2;

    // Zero-extending the assignment to the full variable space makes any
    // var >= NUM_VARS read back as unassigned without a range compare.
    always_comb begin
        w_asg_ext                 = '0;
        w_val_ext                 = '0;
        w_asg_ext[NUM_VARS-1:0]   = assigned;
        w_val_ext[NUM_VARS-1:0]   = value;
    end

    for (genvar i = 0; i < 3; i++) begin : g_lit
        assign w_state[i] = lit_state(w_asg_ext[w_lits[i].var_id],
                                      w_val_ext[w_lits[i].var_id],
                                      w_lits[i]);
    end

    always_comb begin
        w_any_true = 1'b0;
        w_n_unasg  = 2'd0;
        w_free_lit = '0;
        for (int i = 0; i < 3; i++) begin
            if (w_lits[i].var_id != '0) begin
                if (w_state[i] == LIT_TRUE) begin
                    w_any_true = 1'b1;
                end else if (w_state[i] == LIT_UNASSIGNED) begin
                    w_n_unasg  = w_n_unasg + 2'd1;
                    w_free_lit = w_lits[i];
                end
            end
        end
    end

    // An all-empty clause has no TRUE and no unassigned literal, so it falls
    // into CONFLICT naturally.
    always_comb begin
        cls = CLS_OPEN;
        if (w_any_true) begin
            cls = CLS_SAT;
        end else if (w_n_unasg == 2'd0) begin
            cls = CLS_CONFLICT;
        end else if (w_n_unasg == 2'd1) begin
`ifdef CLAUSE_SCANNER_UNIT_EN
            cls = CLS_UNIT;
`else
            cls = CLS_OPEN;
`endif
        end
    end

    assign unit_lit = w_free_lit;

endmodule
`default_nettype wire

// File: rtl/clause_scanner.sv
`default_nettype none
// ============================================================================
// Module      : clause_scanner
// Description : Walks clause memory addresses 0..num_clauses-1 at one clause
//               per cycle, classifies each clause and reports ALL_SAT,
//               CONFLICT, UNIT or UNDECIDED to the assignment controller.
//   clk, rst     clock / synchronous active-high reset
//   start        begin scan (IDLE only); num_clauses sampled with it (clamped to 16)
//   assigned     per-variable assigned flags, held stable while busy
//   value        per-variable values
//   mem_addr     clause memory read address
//   mem_data     clause memory read data, one cycle after mem_addr
//   busy         scan in progress
//   done         one-cycle pulse; status/unit_* valid until the next start
//   status       0 UNDECIDED, 1 ALL_SAT, 2 CONFLICT, 3 UNIT
//   unit_lit     literal to imply (UNIT only)
//   unit_addr    address of the unit or conflict clause
// Config      : CLAUSE_SCANNER_UNIT_EN defined enables UNIT detection; when
//               undefined status is never UNIT and unit_lit stays 0.
// Revision    : 1.0 - initial release
// ============================================================================
module clause_scanner
    import sat_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int NUM_VARS = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W:0]     num_clauses,
    input  logic [NUM_VARS-1:0] assigned,
    input  logic [NUM_VARS-1:0] value,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [CLAUSE_W-1:0] mem_data,
    output logic                busy,
    output logic                done,
    output logic [1:0]          status,
    output logic [LIT_W-1:0]    unit_lit,
    output logic [ADDR_W-1:0]   unit_addr
);

    localparam logic [ADDR_W:0]   c_depth = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   c_one_w = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] c_one_a = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_REPORT = 2'd2
    } state_e;

    state_e            r_state;
    state_e            w_state_nxt;

    logic [ADDR_W:0]   r_num;
    logic [ADDR_W-1:0] r_addr;
    logic              r_issue;      // r_addr holds an address not yet tagged
    logic              r_vld;        // mem_data corresponds to r_tag
    logic [ADDR_W-1:0] r_tag;
    logic              r_has_unit;
    logic              r_has_open;
    logic [LIT_W-1:0]  r_unit_lit;
    logic [ADDR_W-1:0] r_unit_addr;
    logic              r_done;
    logic [1:0]        r_status;
    logic [LIT_W-1:0]  r_out_lit;
    logic [ADDR_W-1:0] r_out_addr;

    logic [1:0]        w_cls;
    logic [LIT_W-1:0]  w_eval_lit;
    logic [ADDR_W:0]   w_num_clamped;
    logic              w_go;
    logic              w_conflict;
    logic              w_unit_now;
    logic              w_open_now;
    logic              w_last;
    logic              w_more;
    logic              w_scan_end;
    logic [1:0]        w_status_fin;
    logic [LIT_W-1:0]  w_lit_fin;
    logic [ADDR_W-1:0] w_addr_fin;

    clause_eval #(
        .NUM_VARS (NUM_VARS)
    ) u_eval (
        .clause   (mem_data),
        .assigned (assigned),
        .value    (value),
        .cls      (w_cls),
        .unit_lit (w_eval_lit)
    );

    assign w_num_clamped = (num_clauses > c_depth) ? c_depth : num_clauses;
    assign w_go          = (r_state == S_IDLE) && start;
    assign w_conflict    = r_vld && (w_cls == CLS_CONFLICT);
    assign w_open_now    = r_vld && (w_cls == CLS_OPEN);
`ifdef CLAUSE_SCANNER_UNIT_EN
    assign w_unit_now    = r_vld && (w_cls == CLS_UNIT);
`else
    assign w_unit_now    = 1'b0;
`endif
    assign w_last        = r_vld && ({1'b0, r_tag} == (r_num - c_one_w));
    assign w_more        = (({1'b0, r_addr} + c_one_w) < r_num);
    // An empty scan still spends one cycle in SCAN, keeping done latency at
    // num_clauses+2 for every count including zero.
    assign w_scan_end    = (r_state == S_SCAN) &&
                           (w_conflict || w_last || (r_num == '0));

    // Final verdict, including the clause being evaluated on the ending cycle.
    always_comb begin
        w_status_fin = ST_ALL_SAT;
        w_lit_fin    = '0;
        w_addr_fin   = '0;
        if (w_conflict) begin
            w_status_fin = ST_CONFLICT;
            w_addr_fin   = r_tag;
        end else if (r_has_unit) begin
            w_status_fin = ST_UNIT;
            w_lit_fin    = r_unit_lit;
            w_addr_fin   = r_unit_addr;
        end else if (w_unit_now) begin
            w_status_fin = ST_UNIT;
            w_lit_fin    = w_eval_lit;
            w_addr_fin   = r_tag;
        end else if (r_has_open || w_open_now) begin
            w_status_fin = ST_UNDECIDED;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start)      w_state_nxt = S_SCAN;
            S_SCAN:   if (w_scan_end) w_state_nxt = S_REPORT;
            S_REPORT:                 w_state_nxt = S_IDLE;
            default:                  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_num       <= '0;
            r_addr      <= '0;
            r_issue     <= 1'b0;
            r_vld       <= 1'b0;
            r_tag       <= '0;
            r_has_unit  <= 1'b0;
            r_has_open  <= 1'b0;
            r_unit_lit  <= '0;
            r_unit_addr <= '0;
            r_done      <= 1'b0;
            r_status    <= ST_UNDECIDED;
            r_out_lit   <= '0;
            r_out_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (r_state == S_REPORT);
            if (w_go) begin
                r_num       <= w_num_clamped;
                r_addr      <= '0;
                r_issue     <= (w_num_clamped != '0);
                r_vld       <= 1'b0;
                r_tag       <= '0;
                r_has_unit  <= 1'b0;
                r_has_open  <= 1'b0;
                r_unit_lit  <= '0;
                r_unit_addr <= '0;
                r_status    <= ST_UNDECIDED;
                r_out_lit   <= '0;
                r_out_addr  <= '0;
            end else if (r_state == S_SCAN) begin
                if (w_scan_end) begin
                    // Address freezes here so an aborted scan shows where it stopped.
                    r_issue    <= 1'b0;
                    r_vld      <= 1'b0;
                    r_status   <= w_status_fin;
                    r_out_lit  <= w_lit_fin;
                    r_out_addr <= w_addr_fin;
                end else begin
                    r_vld <= r_issue;
                    r_tag <= r_addr;
                    if (r_issue) begin
                        if (w_more) begin
                            r_addr <= r_addr + c_one_a;
                        end else begin
                            r_issue <= 1'b0;
                        end
                    end
                    if (w_unit_now && !r_has_unit) begin
                        r_has_unit  <= 1'b1;
                        r_unit_lit  <= w_eval_lit;
                        r_unit_addr <= r_tag;
                    end
                    if (w_open_now) begin
                        r_has_open <= 1'b1;
                    end
                end
            end
        end
    end

    assign mem_addr  = r_addr;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign status    = r_status;
    assign unit_lit  = r_out_lit;
    assign unit_addr = r_out_addr;

endmodule
`default_nettype wire

// File: tb/tb_clause_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_clause_scanner
// Description : Self-checking bench for clause_scanner. A registered clause
//               memory model feeds the scanner; table-driven vectors plus
//               hand-written sequences for restart-while-busy and mid-scan
//               reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clause_scanner;

    localparam int ADDR_W   = 4;
    localparam int NUM_VARS = 64;
    localparam int N_VEC    = 11;
`ifdef CLAUSE_SCANNER_UNIT_EN
    localparam bit UNIT_EN = 1'b1;
`else
    localparam bit UNIT_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [ADDR_W:0]     num_clauses;
    logic [NUM_VARS-1:0] assigned;
    logic [NUM_VARS-1:0] value;
    logic [ADDR_W-1:0]   mem_addr;
    logic [32:0]         mem_data;
    logic                busy;
    logic                done;
    logic [1:0]          status;
    logic [10:0]         unit_lit;
    logic [ADDR_W-1:0]   unit_addr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    clause_scanner #(
        .ADDR_W   (ADDR_W),
        .NUM_VARS (NUM_VARS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_clauses (num_clauses),
        .assigned    (assigned),
        .value       (value),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .busy        (busy),
        .done        (done),
        .status      (status),
        .unit_lit    (unit_lit),
        .unit_addr   (unit_addr)
    );

    logic [32:0] mem [16];
    always @(posedge clk) mem_data <= mem[mem_addr];

    typedef struct {
        logic [16*33-1:0] img;
        logic [4:0]       num;
        logic [1:0]       st;
        logic [10:0]      ulit;
        logic [3:0]       uaddr;
        int               dcyc;
        logic [3:0]       maddr;
    } vec_t;

    vec_t vt [N_VEC];

    function automatic logic [10:0] lit_f(input logic n, input int v);
        logic [9:0] vv;
        vv = v[9:0];
        return {n, vv};
    endfunction

    function automatic logic [32:0] cl_f(input logic [10:0] l2, input logic [10:0] l1, input logic [10:0] l0);
        return {l2, l1, l0};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_cl(input int v, input int k, input logic [32:0] c);
        vt[v].img[k*33 +: 33] = c;
    endtask

    task automatic set_exp(input int v, input int num, input int st, input int ulit,
                           input int uaddr, input int dcyc, input int maddr);
        vt[v].num   = num[4:0];
        vt[v].st    = st[1:0];
        vt[v].ulit  = ulit[10:0];
        vt[v].uaddr = uaddr[3:0];
        vt[v].dcyc  = dcyc;
        vt[v].maddr = maddr[3:0];
    endtask

    task automatic load_mem(input int v);
        for (int k = 0; k < 16; k++) mem[k] = vt[v].img[k*33 +: 33];
    endtask

    task automatic run_vec(input int v);
        int  cyc;
        bit  got;
        load_mem(v);
        num_clauses = vt[v].num;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk($sformatf("v%0d.busy_after_start", v), 32'(busy), 32'd1);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) got = 1'b1;
        end
        chk($sformatf("v%0d.done_seen", v), 32'(got), 32'd1);
        chk($sformatf("v%0d.done_cycle", v), 32'(cyc), 32'(vt[v].dcyc));
        chk($sformatf("v%0d.status", v), 32'(status), 32'(vt[v].st));
        chk($sformatf("v%0d.unit_lit", v), 32'(unit_lit), 32'(vt[v].ulit));
        chk($sformatf("v%0d.unit_addr", v), 32'(unit_addr), 32'(vt[v].uaddr));
        chk($sformatf("v%0d.mem_addr", v), 32'(mem_addr), 32'(vt[v].maddr));
        chk($sformatf("v%0d.busy_at_done", v), 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d.done_pulse", v), 32'(done), 32'd0);
        chk($sformatf("v%0d.status_held", v), 32'(status), 32'(vt[v].st));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [32:0] sat_c, unit5_c, conf_c;
        int          cyc;
        int          n_done;
        int          first_done;

        sat_c   = cl_f(11'd0, 11'd0, lit_f(1'b1, 1));               // !x1, x1=0 -> TRUE
        unit5_c = cl_f(lit_f(1'b0, 5), lit_f(1'b0, 1), lit_f(1'b0, 2));
        conf_c  = cl_f(lit_f(1'b0, 1), lit_f(1'b0, 2), lit_f(1'b0, 3));

        for (int v = 0; v < N_VEC; v++) vt[v].img = '0;

        // 0: four SAT clauses
        set_cl(0, 0, cl_f(lit_f(1'b1, 1), lit_f(1'b0, 2), lit_f(1'b0, 3)));
        set_cl(0, 1, cl_f(11'd0, 11'd0, lit_f(1'b1, 2)));
        set_cl(0, 2, cl_f(lit_f(1'b0, 1), lit_f(1'b1, 3), lit_f(1'b0, 2)));
        set_cl(0, 3, cl_f(lit_f(1'b1, 1), lit_f(1'b1, 2), lit_f(1'b1, 3)));
        set_exp(0, 4, 1, 0, 0, 6, 3);
        // 1: conflict at clause 2 of 5 aborts
        for (int k = 0; k < 5; k++) set_cl(1, k, sat_c);
        set_cl(1, 2, conf_c);
        set_exp(1, 5, 2, 0, 2, 5, 3);
        // 2: unit at clause 1
        set_cl(2, 0, sat_c); set_cl(2, 1, unit5_c); set_cl(2, 2, sat_c);
        set_exp(2, 3, UNIT_EN ? 3 : 0, UNIT_EN ? 5 : 0, UNIT_EN ? 1 : 0, 5, 2);
        // 3: unit at 0, conflict at 3 -> conflict wins
        set_cl(3, 0, unit5_c); set_cl(3, 1, sat_c); set_cl(3, 2, sat_c); set_cl(3, 3, conf_c);
        set_exp(3, 4, 2, 0, 3, 6, 3);
        // 4: empty scan
        set_exp(4, 0, 1, 0, 0, 2, 0);
        // 5: full depth, last clause open
        for (int k = 0; k < 15; k++) set_cl(5, k, sat_c);
        set_cl(5, 15, cl_f(11'd0, lit_f(1'b0, 20), lit_f(1'b0, 21)));
        set_exp(5, 16, 0, 0, 0, 18, 15);
        // 6: count 20 clamps to 16
        for (int k = 0; k < 16; k++) set_cl(6, k, sat_c);
        set_exp(6, 20, 1, 0, 0, 18, 15);
        // 7: all-empty clause 0 is a conflict
        set_cl(7, 1, sat_c); set_cl(7, 2, sat_c);
        set_exp(7, 3, 2, 0, 0, 3, 1);
        // 8: out-of-range variable 100 counts as unassigned
        set_cl(8, 0, cl_f(lit_f(1'b0, 100), lit_f(1'b0, 1), lit_f(1'b0, 2)));
        set_exp(8, 1, UNIT_EN ? 3 : 0, UNIT_EN ? 100 : 0, 0, 3, 0);
        // 9: two units, first (negated x6) kept
        set_cl(9, 0, cl_f(lit_f(1'b0, 1), lit_f(1'b1, 6), lit_f(1'b0, 2)));
        set_cl(9, 1, cl_f(lit_f(1'b1, 7), lit_f(1'b0, 1), lit_f(1'b0, 2)));
        set_exp(9, 2, UNIT_EN ? 3 : 0, UNIT_EN ? 'h406 : 0, 0, 4, 1);
        // 10: two unassigned literals -> open
        set_cl(10, 0, cl_f(lit_f(1'b0, 8), lit_f(1'b0, 9), lit_f(1'b0, 1)));
        set_exp(10, 1, 0, 0, 0, 3, 0);

        // x1..x4 assigned to 0, everything else unassigned
        assigned    = 64'h1E;
        value       = '0;
        start       = 1'b0;
        num_clauses = '0;
        rst         = 1'b1;
        for (int k = 0; k < 16; k++) mem[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.mem_addr", 32'(mem_addr), 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        chk("reset.status", 32'(status), 32'd0);
        chk("reset.unit_lit", 32'(unit_lit), 32'd0);
        chk("reset.unit_addr", 32'(unit_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < N_VEC; v++) run_vec(v);

        // start pulsed while busy: single done, original timing
        load_mem(0);
        num_clauses = 5'd4;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_done = 0;
        first_done = 0;
        for (cyc = 1; cyc <= 14; cyc++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n_done++;
                if (first_done == 0) first_done = cyc;
            end
            if (cyc == 1) begin
                start = 1'b1;
                num_clauses = 5'd0;
            end else begin
                start = 1'b0;
            end
        end
        chk("busy_restart.done_count", 32'(n_done), 32'd1);
        chk("busy_restart.done_cycle", 32'(first_done), 32'd6);
        chk("busy_restart.status", 32'(status), 32'd1);

        // reset at scan cycle 3
        load_mem(0);
        num_clauses = 5'd4;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.mem_addr", 32'(mem_addr), 32'd0);
        chk("midrst.status", 32'(status), 32'd0);
        n_done = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        chk("midrst.no_done", 32'(n_done), 32'd0);
        run_vec(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
